// File: rtl/frame_pattern_engine.sv
// Animated pixel-colour stage: per-frame scroll/counter/mode state plus a
// registered colour path, with hsync/vsync delayed to stay aligned with colour.
module frame_pattern_engine #(
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SCROLL_STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       mode_btn,
  input  logic       pause,
  input  logic       auto_en,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] mode,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    XOR     = 2'd2,
    RINGS   = 2'd3
  } mode_t;

  mode_t      state, state_next;
  logic [7:0] fc;
  logic [9:0] scroll_x;
  logic       btn_prev;

  logic frame_tick, btn_edge, auto_adv;

  assign frame_tick = (hpos == '0) && (vpos == 10'(V_ACTIVE));
  assign btn_edge   = mode_btn & ~btn_prev;
  assign auto_adv   = auto_en & ~pause & (fc == '1);

  // Held button and auto-advance in the same tick still move one step.
  always_comb begin
    state_next = state;
    if (frame_tick && (btn_edge || auto_adv)) begin
      case (state)
        BARS:    state_next = CHECKER;
        CHECKER: state_next = XOR;
        XOR:     state_next = RINGS;
        RINGS:   state_next = BARS;
        default: state_next = BARS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= BARS;
    else       state <= state_next;
  end

  // Frame state moves only on the tick line, so the visible area never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      fc       <= '0;
      scroll_x <= '0;
      btn_prev <= 1'b0;
    end else if (frame_tick) begin
      btn_prev <= mode_btn;
      if (!pause) begin
        fc       <= fc + 8'd1;
        scroll_x <= scroll_x + 10'(SCROLL_STEP);
      end
    end
  end

  // Only the low byte of the scrolled x reaches any pattern.
  logic [7:0] mx;
  logic       c;
  logic [5:0] v_hi;
  logic [3:0] s_hi;
  logic [5:0] rgb_next;

  assign mx   = 8'(hpos + scroll_x);
  assign c    = mx[5] ^ vpos[5];
  assign v_hi = mx[7:2] ^ vpos[7:2];
  assign s_hi = 4'((mx + vpos[7:0] + fc) >> 4);

  always_comb begin
    rgb_next = '0;
    if (display_on) begin
      case (state)
        BARS:    rgb_next = {mx[5], vpos[2], mx[6], vpos[2], mx[7], vpos[5]};
        CHECKER: rgb_next = {c, c, c, 1'b0, ~c, ~c};
        XOR:     rgb_next = v_hi;
        RINGS:   rgb_next = {s_hi[3:2], s_hi[2:1], s_hi[1:0]};
        default: rgb_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      R         <= '0;
      G         <= '0;
      B         <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      R         <= rgb_next[5:4];
      G         <= rgb_next[3:2];
      B         <= rgb_next[1:0];
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

  assign mode        = state;
  assign frame_count = fc;

endmodule

// File: tb/tb_frame_pattern_engine.sv
// Randomised and directed checks of frame_pattern_engine against an
// integer-arithmetic model of the colour rules and per-frame animation state.
module tb_frame_pattern_engine;

  logic       clk = 1'b0;
  logic       reset, hsync_in, vsync_in, display_on, mode_btn, pause, auto_en;
  logic [9:0] hpos, vpos;
  logic [1:0] R, G, B, mode;
  logic       hsync_out, vsync_out;
  logic [7:0] frame_count;

  frame_pattern_engine #(.V_ACTIVE(480), .SCROLL_STEP(1)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .mode_btn(mode_btn),
    .pause(pause), .auto_en(auto_en), .R(R), .G(G), .B(B),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .mode(mode),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int m_mode = 0, m_fc = 0, m_scroll = 0, m_prev = 0;
  int e_rgb = 0, e_hs = 0, e_vs = 0;

  logic [17:0] obs;
  assign obs = {R, G, B, hsync_out, vsync_out, mode, frame_count};

  function automatic int bitof(int x, int n);
    return (x >> n) & 1;
  endfunction

  function automatic int pattern(int md, int hp, int vp, int sc, int fc);
    int mx, r, g, b, c, v, s;
    mx = (hp + sc) % 1024;
    case (md)
      0: begin
        r = bitof(mx, 5) * 2 + bitof(vp, 2);
        g = bitof(mx, 6) * 2 + bitof(vp, 2);
        b = bitof(mx, 7) * 2 + bitof(vp, 5);
      end
      1: begin
        c = bitof(mx, 5) ^ bitof(vp, 5);
        r = 3 * c; g = 2 * c; b = 3 * (1 - c);
      end
      2: begin
        v = (mx % 256) ^ (vp % 256);
        r = v / 64; g = (v / 16) % 4; b = (v / 4) % 4;
      end
      default: begin
        s = (mx % 256 + vp % 256 + fc) % 256;
        r = s / 64; g = (s / 32) % 4; b = (s / 16) % 4;
      end
    endcase
    return r * 16 + g * 4 + b;
  endfunction

  function automatic logic [17:0] expv();
    logic [5:0] rgb;
    logic [1:0] md;
    logic [7:0] fc8;
    rgb = 6'(e_rgb);
    md  = 2'(m_mode);
    fc8 = 8'(m_fc);
    return {rgb, e_hs[0], e_vs[0], md, fc8};
  endfunction

  // Predict from the pre-edge inputs and model, then clock and settle.
  task automatic step();
    bit tick, edge_b, auto_b;
    if (reset) begin
      e_rgb = 0; e_hs = 0; e_vs = 0;
      m_mode = 0; m_fc = 0; m_scroll = 0; m_prev = 0;
    end else begin
      e_rgb = display_on ? pattern(m_mode, int'(hpos), int'(vpos), m_scroll, m_fc) : 0;
      e_hs  = int'(hsync_in);
      e_vs  = int'(vsync_in);
      tick  = (hpos == 0) && (vpos == 480);
      if (tick) begin
        edge_b = mode_btn && (m_prev == 0);
        auto_b = auto_en && !pause && (m_fc == 255);
        if (edge_b || auto_b) m_mode = (m_mode + 1) % 4;
        m_prev = int'(mode_btn);
        if (!pause) begin
          m_fc     = (m_fc + 1) % 256;
          m_scroll = (m_scroll + 1) % 1024;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic btn);
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0; mode_btn = btn;
    step();
    hpos = 10'd100; vpos = 10'd100;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic quiet_inputs();
    hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b0; mode_btn = 1'b0;
    pause = 1'b0; auto_en = 1'b0; hpos = 10'd100; vpos = 10'd100;
  endtask

  task automatic test_reset();
    logic hs_rel;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); display_on = 1'($urandom);
      mode_btn = 1'($urandom); pause = 1'($urandom); auto_en = 1'($urandom);
      hpos = 10'($urandom); vpos = 10'($urandom);
      step();
      total++;
      if (obs !== 18'd0) begin
        bad++; $display("FAIL reset_hold obs=%h exp=%h", obs, 18'd0);
      end
    end
    reset = 1'b0;
    hs_rel = 1'($urandom); hsync_in = hs_rel; hpos = 10'd5; vpos = 10'd5;
    step();
    total++;
    if (hsync_out !== hs_rel || obs !== expv()) begin
      bad++; $display("FAIL reset_release obs=%h exp=%h hs=%b", obs, expv(), hs_rel);
    end
  endtask

  task automatic test_bars();
    do_reset(); quiet_inputs();
    display_on = 1'b1; hpos = 10'd32; vpos = 10'd4;
    step();
    total++;
    if (obs !== expv() || R !== 2'b11 || G !== 2'b01) begin
      bad++; $display("FAIL bars_visible obs=%h exp=%h", obs, expv());
    end
    display_on = 1'b0;
    step();
    total++;
    if ({R, G, B} !== 6'd0 || obs !== expv()) begin
      bad++; $display("FAIL bars_blank obs=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_frame_tick();
    do_reset(); quiet_inputs();
    tick(1'b0);
    total++;
    if (frame_count !== 8'd1 || obs !== expv()) begin
      bad++; $display("FAIL tick_count obs=%h exp=%h", obs, expv());
    end
    display_on = 1'b1; hpos = 10'd31; vpos = 10'd4;
    step();
    total++;
    if (R !== 2'b11 || obs !== expv()) begin
      bad++; $display("FAIL tick_scroll obs=%h exp=%h", obs, expv());
    end
    pause = 1'b1;
    tick(1'b0);
    total++;
    if (frame_count !== 8'd1 || obs !== expv()) begin
      bad++; $display("FAIL tick_pause obs=%h exp=%h", obs, expv());
    end
    pause = 1'b0;
  endtask

  task automatic test_mode_btn();
    logic [1:0] want [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    do_reset(); quiet_inputs();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      total++;
      if (mode !== 2'd1 || obs !== expv()) begin
        bad++; $display("FAIL btn_hold obs=%h exp=%h", obs, expv());
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      tick(1'b1);
      total++;
      if (mode !== want[i] || obs !== expv()) begin
        bad++; $display("FAIL btn_press%0d mode=%0d want=%0d obs=%h exp=%h",
                        i, mode, want[i], obs, expv());
      end
    end
  endtask

  task automatic test_auto_adv();
    do_reset(); quiet_inputs();
    for (int i = 0; i < 255; i++) tick(1'b0);
    total++;
    if (frame_count !== 8'd255 || obs !== expv()) begin
      bad++; $display("FAIL auto_preload obs=%h exp=%h", obs, expv());
    end
    auto_en = 1'b1;
    tick(1'b1);
    total++;
    if (frame_count !== 8'd0 || mode !== 2'd1 || obs !== expv()) begin
      bad++; $display("FAIL auto_and_btn obs=%h exp=%h", obs, expv());
    end
    auto_en = 1'b0;
  endtask

  task automatic test_xor();
    do_reset(); quiet_inputs();
    pause = 1'b1;
    tick(1'b1); tick(1'b0); tick(1'b1);
    display_on = 1'b1; hpos = 10'h0F0; vpos = 10'h00F;
    step();
    total++;
    if (mode !== 2'd2 || {R, G, B} !== 6'h3F || obs !== expv()) begin
      bad++; $display("FAIL xor_ones obs=%h exp=%h", obs, expv());
    end
    vpos = 10'h0F0;
    step();
    total++;
    if ({R, G, B} !== 6'h00 || obs !== expv()) begin
      bad++; $display("FAIL xor_zero obs=%h exp=%h", obs, expv());
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      hsync_in   = 1'($urandom); vsync_in = 1'($urandom);
      display_on = ($urandom_range(0, 3) != 0);
      mode_btn   = 1'($urandom); pause = ($urandom_range(0, 3) == 0);
      auto_en    = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        hpos = 10'd0; vpos = 10'd480;
      end else begin
        hpos = 10'($urandom); vpos = 10'($urandom);
      end
      step();
      total++;
      if (obs !== expv()) begin
        bad++; errs++;
        if (errs <= 10) $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    quiet_inputs();
    test_reset();
    test_bars();
    test_frame_tick();
    test_mode_btn();
    test_auto_adv();
    test_xor();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
